// File: rtl/dram_slot_ctrl.sv
// dram_slot_ctrl: per-slot DRAM sequencer and arbiter.
// Each 16-cycle slot has two sub-slots. Sub-slot A (ph 0-7) serves video, then
// DMA. Sub-slot B (ph 8-15) serves the CPU. Either sub-slot may instead carry a
// pending RAS-only refresh. All DRAM-facing outputs are registered from
// next-state values, so each output matches the phase the register is entering.
module dram_slot_ctrl #(
  parameter int AW            = 20,
  parameter int REFRESH_SLOTS = 32
) (
  input  logic          clk32,
  input  logic          resb,
  input  logic          slot_start,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  output logic          vid_ack,
  output logic          dma_ack,
  output logic          cpu_ack,
  output logic [1:0]    owner,
  output logic          refresh,
  output logic          ras_n,
  output logic          cas_n,
  output logic          we_n,
  output logic [AW/2-1:0] ma
);

  localparam int HW = AW / 2;
  // The slot counter only has to reach REFRESH_SLOTS-2 before it wraps.
  localparam int CW = (REFRESH_SLOTS > 2) ? $clog2(REFRESH_SLOTS) : 1;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

  logic [3:0]    ph_reg, ph_next;
  logic          synced_reg, synced_next;
  owner_t        owner_reg, owner_next;
  logic          refresh_reg, refresh_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic          we_reg, we_next;
  logic          rfp_reg, rfp_next;
  logic [CW-1:0] rf_cnt_reg, rf_cnt_next;
  logic [HW-1:0] rrow_reg, rrow_next;

  logic          ras_n_reg, ras_n_next;
  logic          cas_n_reg, cas_n_next;
  logic          we_n_reg, we_n_next;
  logic [HW-1:0] ma_reg, ma_next;
  logic          vid_ack_reg, vid_ack_next;
  logic          dma_ack_reg, dma_ack_next;
  logic          cpu_ack_reg, cpu_ack_next;

  logic [2:0]    q_next;
  logic          active_next;

  // Next-state: phase, arbitration decisions, refresh bookkeeping, strobes.
  always_comb begin
    ph_next      = slot_start ? 4'd0 : ph_reg + 4'd1;
    synced_next  = synced_reg | slot_start;
    owner_next   = owner_reg;
    refresh_next = refresh_reg;
    addr_next    = addr_reg;
    we_next      = we_reg;
    rfp_next     = rfp_reg;
    rf_cnt_next  = rf_cnt_reg;
    rrow_next    = rrow_reg;

    // The refresh row advances as a refresh sub-slot leaves its last phase.
    if (refresh_reg && (ph_reg[2:0] == 3'd7)) begin
      rrow_next = rrow_reg + HW'(1);
    end

    if (slot_start) begin
      // Sub-slot A decision. slot_start itself establishes sync, so the very
      // first pulse already arbitrates. Any access still running is dropped
      // here, which is what aborts an access on an early slot_start.
      owner_next   = OWN_IDLE;
      refresh_next = 1'b0;
      if (vid_req) begin
        owner_next = OWN_VID;
        addr_next  = vid_addr;
        we_next    = 1'b0;
      end else if (dma_req) begin
        owner_next = OWN_DMA;
        addr_next  = dma_addr;
        we_next    = dma_we;
      end else if (rfp_reg) begin
        refresh_next = 1'b1;
        rfp_next     = 1'b0;
      end
      // The count wraps when it would reach REFRESH_SLOTS-1; a wrap on the
      // same edge as a refresh decision leaves rfp set, and a wrap while rfp
      // is already set is simply absorbed.
      if (rf_cnt_reg == CW'(REFRESH_SLOTS - 2)) begin
        rf_cnt_next = '0;
        rfp_next    = 1'b1;
      end else begin
        rf_cnt_next = rf_cnt_reg + CW'(1);
      end
    end else if (synced_reg && (ph_reg == 4'd7)) begin
      // Sub-slot B decision.
      owner_next   = OWN_IDLE;
      refresh_next = 1'b0;
      if (cpu_req) begin
        owner_next = OWN_CPU;
        addr_next  = cpu_addr;
        we_next    = cpu_we;
      end else if (rfp_reg) begin
        refresh_next = 1'b1;
        rfp_next     = 1'b0;
      end
    end else if (ph_reg == 4'd15) begin
      // A missing slot_start leaves sub-slot A undecided and idle.
      owner_next   = OWN_IDLE;
      refresh_next = 1'b0;
    end

    // Refresh carries no requester code (owner stays 0) but still drives RAS.
    q_next      = ph_next[2:0];
    active_next = (owner_next != OWN_IDLE) || refresh_next;

    ras_n_next = ~(active_next && (q_next >= 3'd1) && (q_next <= 3'd6));
    cas_n_next = ~(active_next && !refresh_next &&
                   (q_next >= 3'd3) && (q_next <= 3'd6));
    we_n_next  = ~(active_next && !refresh_next && we_next &&
                   (q_next >= 3'd2) && (q_next <= 3'd6));

    ma_next = '0;
    if (active_next) begin
      if (refresh_next) begin
        ma_next = rrow_next;
      end else if (q_next <= 3'd2) begin
        ma_next = addr_next[AW-1:HW];
      end else begin
        ma_next = addr_next[HW-1:0];
      end
    end

    vid_ack_next = (owner_next == OWN_VID) && (ph_next == 4'd6);
    dma_ack_next = (owner_next == OWN_DMA) && (ph_next == 4'd6);
    cpu_ack_next = (owner_next == OWN_CPU) && (ph_next == 4'd14);
  end

  // State and registered outputs; reset forces strobes inactive at once.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      ph_reg      <= 4'd0;
      synced_reg  <= 1'b0;
      owner_reg   <= OWN_IDLE;
      refresh_reg <= 1'b0;
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      rfp_reg     <= 1'b0;
      rf_cnt_reg  <= '0;
      rrow_reg    <= '0;
      ras_n_reg   <= 1'b1;
      cas_n_reg   <= 1'b1;
      we_n_reg    <= 1'b1;
      ma_reg      <= '0;
      vid_ack_reg <= 1'b0;
      dma_ack_reg <= 1'b0;
      cpu_ack_reg <= 1'b0;
    end else begin
      ph_reg      <= ph_next;
      synced_reg  <= synced_next;
      owner_reg   <= owner_next;
      refresh_reg <= refresh_next;
      addr_reg    <= addr_next;
      we_reg      <= we_next;
      rfp_reg     <= rfp_next;
      rf_cnt_reg  <= rf_cnt_next;
      rrow_reg    <= rrow_next;
      ras_n_reg   <= ras_n_next;
      cas_n_reg   <= cas_n_next;
      we_n_reg    <= we_n_next;
      ma_reg      <= ma_next;
      vid_ack_reg <= vid_ack_next;
      dma_ack_reg <= dma_ack_next;
      cpu_ack_reg <= cpu_ack_next;
    end
  end

  assign owner   = owner_reg;
  assign refresh = refresh_reg;
  assign ras_n   = ras_n_reg;
  assign cas_n   = cas_n_reg;
  assign we_n    = we_n_reg;
  assign ma      = ma_reg;
  assign vid_ack = vid_ack_reg;
  assign dma_ack = dma_ack_reg;
  assign cpu_ack = cpu_ack_reg;

endmodule

// File: tb/tb_dram_slot_ctrl.sv
// Directed bench for dram_slot_ctrl: runs whole slots, logs outputs per phase,
// and checks them against hand-derived values.
module tb_dram_slot_ctrl;

  localparam int AW = 20;

  logic          clk32 = 1'b0;
  logic          resb = 1'b0;
  logic          slot_start = 1'b0;
  logic          vid_req = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] vid_addr = '0, dma_addr = '0, cpu_addr = '0;
  logic          vid_ack, dma_ack, cpu_ack, refresh, ras_n, cas_n, we_n;
  logic [1:0]    owner;
  logic [9:0]    ma;

  int tests = 0;
  int fails = 0;

  logic       ras_l[16], cas_l[16], we_l[16], ref_l[16];
  logic       vack_l[16], dack_l[16], cack_l[16];
  logic [1:0] own_l[16];
  logic [9:0] ma_l[16];

  dram_slot_ctrl #(.AW(AW), .REFRESH_SLOTS(32)) dut (
    .clk32(clk32), .resb(resb), .slot_start(slot_start),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .vid_ack(vid_ack), .dma_ack(dma_ack), .cpu_ack(cpu_ack),
    .owner(owner), .refresh(refresh),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ma(ma)
  );

  always #5 clk32 = ~clk32;

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic step(input logic ss);
    slot_start = ss;
    @(posedge clk32);
    #1;
    slot_start = 1'b0;
  endtask

  task automatic log_at(input int p);
    ras_l[p] = ras_n;  cas_l[p] = cas_n;  we_l[p] = we_n;  ref_l[p] = refresh;
    vack_l[p] = vid_ack; dack_l[p] = dma_ack; cack_l[p] = cpu_ack;
    own_l[p] = owner;  ma_l[p] = ma;
  endtask

  // Runs one slot; requesters drop req on their ack. cpu_req rises after
  // phase req_at when req_at is 0..15.
  task automatic run_slot(input int req_at);
    for (int p = 0; p < 16; p++) begin
      step(p == 0);
      log_at(p);
      if (vid_ack) vid_req = 1'b0;
      if (dma_ack) dma_req = 1'b0;
      if (cpu_ack) cpu_req = 1'b0;
      if (p == req_at) cpu_req = 1'b1;
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(posedge clk32);
    #1;
    tests++;
    if ({ras_n, cas_n, we_n} !== 3'b111) begin
      fails++; $display("FAIL reset_strobes: got %b want 111", {ras_n, cas_n, we_n});
    end
    tests++;
    if ({vid_ack, dma_ack, cpu_ack, refresh, owner, ma} !== 16'h0) begin
      fails++; $display("FAIL reset_outs: got %h want 0", {vid_ack, dma_ack, cpu_ack, refresh, owner, ma});
    end
    @(posedge clk32); #1;
    resb = 1'b1;
    cpu_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      if (ras_n !== 1'b1 || owner !== 2'd0 || cpu_ack !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL unsynced_idle: got %0d active cycles want 0", bad);
    end
    cpu_req = 1'b0;
    $display("[TB] reset and unsynced free-run done");
  endtask

  task automatic test_refresh_idle();
    int lows;
    for (int s = 1; s <= 30; s++) begin
      run_slot(-1);
      lows = 0;
      for (int p = 0; p < 16; p++) if (ras_l[p] !== 1'b1) lows++;
      tests++;
      if (lows !== 0) begin
        fails++; $display("FAIL idle_slot%0d_ras: got %0d low phases want 0", s, lows);
      end
    end
    run_slot(-1);  // slot 31: refresh pending from its slot_start, done in B
    for (int p = 0; p < 16; p++) begin
      logic exp_ras, exp_ref;
      exp_ras = !(p >= 9 && p <= 14);
      exp_ref = (p >= 8);
      tests++;
      if (ras_l[p] !== exp_ras || cas_l[p] !== 1'b1 || ref_l[p] !== exp_ref ||
          ma_l[p] !== 10'h000 || own_l[p] !== 2'd0) begin
        fails++;
        $display("FAIL refresh1_p%0d: got ras=%b cas=%b ref=%b ma=%h own=%0d want ras=%b cas=1 ref=%b ma=000 own=0",
                 p, ras_l[p], cas_l[p], ref_l[p], ma_l[p], own_l[p], exp_ras, exp_ref);
      end
    end
    $display("[TB] slots 1-31 idle with first refresh");
  endtask

  task automatic test_video();
    vid_req = 1'b1; vid_addr = 20'h3A5C7;
    run_slot(-1);  // slot 32
    for (int p = 0; p < 8; p++) begin
      logic [9:0] exp_ma;
      logic exp_ras, exp_cas, exp_ack;
      exp_ma  = (p <= 2) ? 10'h0E9 : 10'h1C7;
      exp_ras = !(p >= 1 && p <= 6);
      exp_cas = !(p >= 3 && p <= 6);
      exp_ack = (p == 6);
      tests++;
      if (ma_l[p] !== exp_ma || ras_l[p] !== exp_ras || cas_l[p] !== exp_cas ||
          we_l[p] !== 1'b1 || vack_l[p] !== exp_ack || own_l[p] !== 2'd1) begin
        fails++;
        $display("FAIL video_p%0d: got ma=%h ras=%b cas=%b we=%b ack=%b own=%0d want ma=%h ras=%b cas=%b we=1 ack=%b own=1",
                 p, ma_l[p], ras_l[p], cas_l[p], we_l[p], vack_l[p], own_l[p], exp_ma, exp_ras, exp_cas, exp_ack);
      end
    end
    tests++;
    if (own_l[8] !== 2'd0 || ras_l[10] !== 1'b1 || ref_l[8] !== 1'b0) begin
      fails++; $display("FAIL video_subB_idle: got own=%0d ras=%b ref=%b want 0 1 0", own_l[8], ras_l[10], ref_l[8]);
    end
    $display("[TB] slot 32 video read 0x3A5C7");
  endtask

  task automatic test_vid_dma();
    vid_req = 1'b1; vid_addr = 20'h11111;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 20'h2A815;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00000;
    run_slot(-1);  // slot 33
    tests++;
    if (own_l[0] !== 2'd1 || vack_l[6] !== 1'b1 || dack_l[6] !== 1'b0) begin
      fails++; $display("FAIL vd_slotA: got own=%0d vack=%b dack=%b want 1 1 0", own_l[0], vack_l[6], dack_l[6]);
    end
    tests++;
    if (own_l[8] !== 2'd3 || cack_l[14] !== 1'b1) begin
      fails++; $display("FAIL vd_cpu_B: got own=%0d cack=%b want 3 1", own_l[8], cack_l[14]);
    end
    run_slot(-1);  // slot 34
    tests++;
    if (own_l[0] !== 2'd2 || dack_l[6] !== 1'b1 || vack_l[6] !== 1'b0) begin
      fails++; $display("FAIL vd_dma_A: got own=%0d dack=%b vack=%b want 2 1 0", own_l[0], dack_l[6], vack_l[6]);
    end
    tests++;
    if (ma_l[1] !== 10'h0AA || ma_l[4] !== 10'h015) begin
      fails++; $display("FAIL vd_dma_ma: got row=%h col=%h want 0AA 015", ma_l[1], ma_l[4]);
    end
    for (int p = 0; p < 8; p++) begin
      logic exp_we;
      exp_we = !(p >= 2 && p <= 6);
      tests++;
      if (we_l[p] !== exp_we) begin
        fails++; $display("FAIL vd_dma_we_p%0d: got %b want %b", p, we_l[p], exp_we);
      end
    end
    tests++;
    if (own_l[8] !== 2'd0) begin
      fails++; $display("FAIL vd_slot34_B: got own=%0d want 0", own_l[8]);
    end
    $display("[TB] slots 33-34 video, cpu, then dma write");
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00401;
    run_slot(-1);  // slot 35
    for (int p = 0; p < 16; p++) begin
      logic exp_we, exp_ras, exp_cas, exp_ack;
      logic [9:0] exp_ma;
      exp_we  = !(p >= 10 && p <= 14);
      exp_ras = !(p >= 9 && p <= 14);
      exp_cas = !(p >= 11 && p <= 14);
      exp_ack = (p == 14);
      exp_ma  = (p >= 8) ? 10'h001 : 10'h000;
      tests++;
      if (we_l[p] !== exp_we || ras_l[p] !== exp_ras || cas_l[p] !== exp_cas ||
          cack_l[p] !== exp_ack || ma_l[p] !== exp_ma) begin
        fails++;
        $display("FAIL cpuwr_p%0d: got we=%b ras=%b cas=%b ack=%b ma=%h want we=%b ras=%b cas=%b ack=%b ma=%h",
                 p, we_l[p], ras_l[p], cas_l[p], cack_l[p], ma_l[p], exp_we, exp_ras, exp_cas, exp_ack, exp_ma);
      end
    end
    cpu_we = 1'b0;
    $display("[TB] slot 35 cpu write 0x00401");
  endtask

  task automatic test_late_req();
    cpu_addr = 20'h00C03;
    run_slot(7);  // slot 36: cpu_req present at ph=7
    tests++;
    if (own_l[8] !== 2'd3 || ma_l[8] !== 10'h003 || ma_l[11] !== 10'h003) begin
      fails++; $display("FAIL late_B: got own=%0d row=%h col=%h want 3 003 003", own_l[8], ma_l[8], ma_l[11]);
    end
    for (int p = 8; p < 16; p++) begin
      tests++;
      if (cack_l[p] !== (p == 14)) begin
        fails++; $display("FAIL late_ack_p%0d: got %b want %b", p, cack_l[p], (p == 14));
      end
    end
    $display("[TB] slot 36 cpu request at ph=7");
  endtask

  task automatic test_cpu_vs_refresh();
    int lows;
    lows = 0;
    for (int s = 37; s <= 60; s++) begin
      run_slot(-1);
      for (int p = 0; p < 16; p++) if (ras_l[p] !== 1'b1) lows++;
    end
    tests++;
    if (lows !== 0) begin
      fails++; $display("FAIL idle37_60: got %0d low phases want 0", lows);
    end
    cpu_addr = 20'h12345;
    run_slot(12);  // slot 61: cpu_req rises after B was decided
    tests++;
    if (own_l[8] !== 2'd0 || cack_l[14] !== 1'b0) begin
      fails++; $display("FAIL s61_B: got own=%0d cack=%b want 0 0", own_l[8], cack_l[14]);
    end
    run_slot(-1);  // slot 62: refresh pending, CPU wins B
    tests++;
    if (own_l[8] !== 2'd3 || ref_l[8] !== 1'b0 || cack_l[14] !== 1'b1 || ref_l[0] !== 1'b0) begin
      fails++; $display("FAIL s62_cpu_wins: got own=%0d ref=%b cack=%b refA=%b want 3 0 1 0",
                        own_l[8], ref_l[8], cack_l[14], ref_l[0]);
    end
    run_slot(-1);  // slot 63: refresh lands in A, row counter now 1
    for (int p = 0; p < 8; p++) begin
      logic exp_ras;
      exp_ras = !(p >= 1 && p <= 6);
      tests++;
      if (ref_l[p] !== 1'b1 || ras_l[p] !== exp_ras || cas_l[p] !== 1'b1 || ma_l[p] !== 10'h001) begin
        fails++;
        $display("FAIL refresh2_p%0d: got ref=%b ras=%b cas=%b ma=%h want ref=1 ras=%b cas=1 ma=001",
                 p, ref_l[p], ras_l[p], cas_l[p], ma_l[p], exp_ras);
      end
    end
    tests++;
    if (ref_l[8] !== 1'b0 || ras_l[10] !== 1'b1) begin
      fails++; $display("FAIL refresh2_B: got ref=%b ras=%b want 0 1", ref_l[8], ras_l[10]);
    end
    $display("[TB] slots 37-63 cpu beats pending refresh");
  endtask

  task automatic test_resync();
    int early;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00C03;
    for (int p = 0; p < 10; p++) step(p == 0);
    tests++;
    if (ras_n !== 1'b0 || owner !== 2'd3) begin
      fails++; $display("FAIL resync_pre: got ras=%b own=%0d want 0 3", ras_n, owner);
    end
    step(1'b1);  // slot_start while ph=9
    tests++;
    if ({ras_n, cas_n, we_n} !== 3'b111 || owner !== 2'd0 || cpu_ack !== 1'b0) begin
      fails++; $display("FAIL resync_abort: got strobes=%b own=%0d cack=%b want 111 0 0",
                        {ras_n, cas_n, we_n}, owner, cpu_ack);
    end
    log_at(0);
    for (int p = 1; p < 16; p++) begin
      step(1'b0);
      log_at(p);
      if (cpu_ack) cpu_req = 1'b0;
    end
    early = 0;
    for (int p = 0; p < 14; p++) if (cack_l[p] !== 1'b0) early++;
    for (int p = 0; p < 8; p++) if (ras_l[p] !== 1'b1) early++;
    tests++;
    if (early !== 0 || own_l[8] !== 2'd3 || cack_l[14] !== 1'b1) begin
      fails++; $display("FAIL resync_next: got bad=%0d own=%0d cack14=%b want 0 3 1", early, own_l[8], cack_l[14]);
    end
    cpu_we = 1'b0;
    $display("[TB] resync at ph=9 aborts cpu access");
  endtask

  task automatic test_async_reset();
    int acks;
    vid_req = 1'b1; vid_addr = 20'h3A5C7;
    for (int p = 0; p < 4; p++) step(p == 0);
    tests++;
    if (cas_n !== 1'b0 || ras_n !== 1'b0) begin
      fails++; $display("FAIL areset_pre: got ras=%b cas=%b want 0 0", ras_n, cas_n);
    end
    #2;
    resb = 1'b0;
    #1;
    tests++;
    if ({ras_n, cas_n, we_n} !== 3'b111 || owner !== 2'd0 || ma !== 10'h000) begin
      fails++; $display("FAIL areset_now: got strobes=%b own=%0d ma=%h want 111 0 000",
                        {ras_n, cas_n, we_n}, owner, ma);
    end
    vid_req = 1'b0;
    repeat (2) @(posedge clk32);
    #1;
    resb = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      if (vid_ack !== 1'b0 || ras_n !== 1'b1) acks++;
    end
    tests++;
    if (acks !== 0) begin
      fails++; $display("FAIL areset_noack: got %0d bad cycles want 0", acks);
    end
    $display("[TB] asynchronous reset mid-access");
  endtask

  initial begin
    test_reset();
    test_refresh_idle();
    test_video();
    test_vid_dma();
    test_cpu_write();
    test_late_req();
    test_cpu_vs_refresh();
    test_resync();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
